// File: rtl/alu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_if
// Bus between the ALU check sequencer (master) and the ALU under test (slave).
//   alu_a, alu_b : 4-bit operands, driven by the sequencer
//   alu_s        : 3-bit opcode, driven by the sequencer
//   alu_out      : 4-bit ALU result, returned by the ALU
//   alu_carry    : ALU carry/borrow flag, returned by the ALU
//   alu_zero     : ALU zero flag, returned by the ALU
// ---------------------------------------------------------------------------
interface alu_op_sequencer_if;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_s;
  logic [3:0] alu_out;
  logic       alu_carry;
  logic       alu_zero;

  modport master (
    output alu_a, alu_b, alu_s,
    input  alu_out, alu_carry, alu_zero
  );

  modport slave (
    input  alu_a, alu_b, alu_s,
    output alu_out, alu_carry, alu_zero
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Runs a self-test of an external 4-bit ALU: on start it latches two seed
// operands, steps through all eight opcodes, holds each opcode/operand set for
// SETTLE_CYCLES cycles, then compares the ALU answer against a built-in golden
// model and tallies passes, failures and which opcodes failed.
//
// Ports
//   clk           : rising-edge clock
//   rst_n         : asynchronous active-low reset (forces IDLE, clears outputs)
//   start         : one-cycle request, honoured only in IDLE
//   a_seed/b_seed : 4-bit operands latched on an accepted start
//   alu           : master side of alu_op_sequencer_if (alu_a/alu_b/alu_s out,
//                   alu_out/alu_carry/alu_zero in)
//   busy          : high while DRIVE or CHECK
//   done          : one-cycle pulse (DONE state) at the end of a run
//   pass_cnt      : number of opcodes that matched the model
//   fail_cnt      : number of opcodes that mismatched
//   mismatch_vec  : bit k set when opcode k mismatched
//   first_fail_op : opcode of the first mismatch of the run (0 if none)
//
// Parameter
//   SETTLE_CYCLES : cycles the operands settle before sampling (min 1)
//
// Build option
//   ALU_SEQ_HALT_ON_FAIL_EN : when defined, the first mismatch ends the run
//                             immediately instead of checking all opcodes.
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [3:0]          a_seed,
  input  logic [3:0]          b_seed,
  alu_op_sequencer_if.master  alu,
  output logic                busy,
  output logic                done,
  output logic [3:0]          pass_cnt,
  output logic [3:0]          fail_cnt,
  output logic [7:0]          mismatch_vec,
  output logic [2:0]          first_fail_op
);

  localparam int          SETTLE      = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] settle_q;
  logic [3:0]  alu_a_q, alu_b_q;
  logic [2:0]  alu_s_q;
  logic [3:0]  pass_cnt_q, fail_cnt_q;
  logic [7:0]  mismatch_vec_q;
  logic [2:0]  first_fail_op_q;

  logic [5:0]  model;
  logic        match;

  // Golden ALU: returns {carry, zero, result[3:0]}.
  function automatic logic [5:0] alu_model(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic [2:0] s);
    logic [4:0] wide;
    logic [3:0] res;
    logic       c;
    wide = 5'd0;
    res  = 4'd0;
    c    = 1'b0;
    case (s)
      3'd0: begin wide = {1'b0, a} + {1'b0, b}; res = wide[3:0]; c = wide[4]; end
      3'd1: begin res = a - b; c = (a < b); end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = ~a;
      3'd6: begin res = {a[2:0], 1'b0}; c = a[3]; end
      default: begin res = {1'b0, a[3:1]}; c = a[0]; end
    endcase
    return {c, (res == 4'd0), res};
  endfunction

  assign model = alu_model(alu_a_q, alu_b_q, alu_s_q);
  assign match = (alu.alu_out == model[3:0]) &&
                 (alu.alu_carry == model[5]) &&
                 (alu.alu_zero == model[4]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_DRIVE;
      S_DRIVE: if (settle_q == SETTLE_LAST) state_d = S_CHECK;
      S_CHECK: begin
        if (alu_s_q == 3'd7) state_d = S_DONE;
`ifdef ALU_SEQ_HALT_ON_FAIL_EN
        else if (!match) state_d = S_DONE;
`endif
        else state_d = S_DRIVE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      settle_q        <= 16'd0;
      alu_a_q         <= 4'd0;
      alu_b_q         <= 4'd0;
      alu_s_q         <= 3'd0;
      pass_cnt_q      <= 4'd0;
      fail_cnt_q      <= 4'd0;
      mismatch_vec_q  <= 8'd0;
      first_fail_op_q <= 3'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            alu_a_q         <= a_seed;
            alu_b_q         <= b_seed;
            alu_s_q         <= 3'd0;
            settle_q        <= 16'd0;
            pass_cnt_q      <= 4'd0;
            fail_cnt_q      <= 4'd0;
            mismatch_vec_q  <= 8'd0;
            first_fail_op_q <= 3'd0;
          end
        end
        S_DRIVE: settle_q <= settle_q + 16'd1;
        S_CHECK: begin
          if (match) begin
            pass_cnt_q <= pass_cnt_q + 4'd1;
          end else begin
            fail_cnt_q              <= fail_cnt_q + 4'd1;
            mismatch_vec_q[alu_s_q] <= 1'b1;
            // No earlier failure in this run means this one is the first.
            if (fail_cnt_q == 4'd0) first_fail_op_q <= alu_s_q;
          end
          // Operands only move when the next DRIVE phase begins.
          if (state_d == S_DRIVE) begin
            alu_s_q  <= alu_s_q + 3'd1;
            settle_q <= 16'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu.alu_a     = alu_a_q;
  assign alu.alu_b     = alu_b_q;
  assign alu.alu_s     = alu_s_q;
  assign busy          = (state_q == S_DRIVE) || (state_q == S_CHECK);
  assign done          = (state_q == S_DONE);
  assign pass_cnt      = pass_cnt_q;
  assign fail_cnt      = fail_cnt_q;
  assign mismatch_vec  = mismatch_vec_q;
  assign first_fail_op = first_fail_op_q;

endmodule
